mcdf_fifo_arbiter: RTL and testbench

//  Packet scheduler sitting between the three slave-channel FIFOs and the formatter.

---
 rtl/mcdf_fifo_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mcdf_fifo_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcdf_fifo_arbiter.sv
// mcdf_fifo_arbiter
//   Packet scheduler between three slave-channel FIFOs and the formatter.
//   Waits for an enabled channel that holds at least one full packet,
//   requests the formatter, and once granted drains exactly one packet of
//   LEN words from that FIFO. The words are streamed out with start and end
//   markers. The winner is the eligible channel with the numerically smallest
//   priority; on equal priority the lowest channel id wins.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   ch_en        per-channel enable
//   ch_prio      2-bit priority per channel, [2i+1:2i], 0 = highest
//   pkt_len_sel  packet length select: 000:4 001:8 010:16 others:32
//   ch_level     per-channel FIFO fill level, LVL_W bits each
//   ch_empty     per-channel FIFO empty flags
//   ch_data      per-channel FIFO read data, valid one cycle after a read
//   ch_rd_en     one-hot FIFO read strobe
//   fmt_req      packet request to the formatter
//   fmt_grant    formatter grant, only looked at while requesting
//   fmt_chid     channel id of the current packet
//   fmt_length   length of the current packet in words
//   fmt_valid    fmt_data carries a packet word
//   fmt_start    first word of the packet
//   fmt_end      last word of the packet
//   fmt_data     packet word, zero when fmt_valid is low
module mcdf_fifo_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LVL_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              ch_en,
    input  logic [5:0]              ch_prio,
    input  logic [2:0]              pkt_len_sel,
    input  logic [3*LVL_W-1:0]      ch_level,
    input  logic [2:0]              ch_empty,
    input  logic [3*DATA_WIDTH-1:0] ch_data,
    output logic [2:0]              ch_rd_en,
    output logic                    fmt_req,
    input  logic                    fmt_grant,
    output logic [1:0]              fmt_chid,
    output logic [5:0]              fmt_length,
    output logic                    fmt_valid,
    output logic                    fmt_start,
    output logic                    fmt_end,
    output logic [DATA_WIDTH-1:0]   fmt_data
);

    typedef enum logic [1:0] {IDLE, REQ, SEND, FLUSH} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            chid_reg;
    logic [5:0]            length_reg;
    logic [5:0]            rd_cnt_reg;
    logic [5:0]            out_cnt_reg;
    logic                  valid_reg;

    logic [5:0]            cur_len;
    logic [2:0]            elig;
    logic [1:0]            prio      [3];
    logic [DATA_WIDTH-1:0] data_arr  [3];
    logic [2:0]            rd_en_vec;
    logic                  rd_issue;
    logic                  win_any;
    logic [1:0]            win_id;
    logic [1:0]            win_prio;
    logic [DATA_WIDTH-1:0] sel_data;

    // Length currently selected; it is only sampled when leaving IDLE.
    always_comb begin
        cur_len = 6'd32;
        case (pkt_len_sel)
            3'b000:  cur_len = 6'd4;
            3'b001:  cur_len = 6'd8;
            3'b010:  cur_len = 6'd16;
            default: cur_len = 6'd32;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            assign prio[gi]      = ch_prio[2*gi +: 2];
            assign data_arr[gi]  = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
            // A channel qualifies once it holds a complete packet.
            assign elig[gi]      = ch_en[gi] &
                                   (ch_level[gi*LVL_W +: LVL_W] >= LVL_W'(cur_len));
            // Reads only go to the latched channel and never from an empty FIFO.
            assign rd_en_vec[gi] = (state_reg == SEND) && (chid_reg == 2'(gi)) &&
                                   !ch_empty[gi];
        end
    endgenerate

    assign rd_issue = |rd_en_vec;

    // Scanning upward with a strict compare keeps the lowest id on a tie.
    always_comb begin
        win_any  = 1'b0;
        win_id   = 2'd0;
        win_prio = 2'd3;
        for (int i = 0; i < 3; i++) begin
            if (elig[i] && (!win_any || (prio[i] < win_prio))) begin
                win_any  = 1'b1;
                win_id   = 2'(i);
                win_prio = prio[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_any) state_next = REQ;
            REQ:     if (fmt_grant) state_next = SEND;
            // Leave as soon as the LEN-th read is issued.
            SEND:    if (rd_issue && (rd_cnt_reg == length_reg - 6'd1)) state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            chid_reg    <= 2'd0;
            length_reg  <= 6'd0;
            rd_cnt_reg  <= 6'd0;
            out_cnt_reg <= 6'd0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= rd_issue;
            if ((state_reg == IDLE) && win_any) begin
                chid_reg   <= win_id;
                length_reg <= cur_len;
            end
            if (state_reg == IDLE) begin
                rd_cnt_reg <= 6'd0;
            end else if (rd_issue) begin
                rd_cnt_reg <= rd_cnt_reg + 6'd1;
            end
            // Counts delivered words so start/end follow the data, not the reads.
            if (state_reg == IDLE) begin
                out_cnt_reg <= 6'd0;
            end else if (valid_reg) begin
                out_cnt_reg <= out_cnt_reg + 6'd1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (chid_reg == 2'(i)) sel_data = data_arr[i];
        end
    end

    assign ch_rd_en   = rd_en_vec;
    assign fmt_req    = (state_reg == REQ);
    assign fmt_chid   = chid_reg;
    assign fmt_length = length_reg;
    assign fmt_valid  = valid_reg;
    assign fmt_data   = valid_reg ? sel_data : '0;
    assign fmt_start  = valid_reg && (out_cnt_reg == 6'd0);
    assign fmt_end    = valid_reg && (out_cnt_reg == length_reg - 6'd1);

endmodule

// File: tb/tb_mcdf_fifo_arbiter.sv
module tb_mcdf_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ch_en;
    logic [5:0]  ch_prio;
    logic [2:0]  pkt_len_sel;
    logic [20:0] ch_level;
    logic [2:0]  ch_empty;
    logic [95:0] ch_data;
    logic [2:0]  ch_rd_en;
    logic        fmt_req;
    logic        fmt_grant;
    logic [1:0]  fmt_chid;
    logic [5:0]  fmt_length;
    logic        fmt_valid;
    logic        fmt_start;
    logic        fmt_end;
    logic [31:0] fmt_data;

    always #5 clk = ~clk;

    mcdf_fifo_arbiter #(.DATA_WIDTH(32), .LVL_W(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_en       (ch_en),
        .ch_prio     (ch_prio),
        .pkt_len_sel (pkt_len_sel),
        .ch_level    (ch_level),
        .ch_empty    (ch_empty),
        .ch_data     (ch_data),
        .ch_rd_en    (ch_rd_en),
        .fmt_req     (fmt_req),
        .fmt_grant   (fmt_grant),
        .fmt_chid    (fmt_chid),
        .fmt_length  (fmt_length),
        .fmt_valid   (fmt_valid),
        .fmt_start   (fmt_start),
        .fmt_end     (fmt_end),
        .fmt_data    (fmt_data)
    );

    // ---------------- FIFO models ----------------
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [31:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0]  lvl0 = '0, lvl1 = '0, lvl2 = '0;
    logic [2:0]  emp_reg = 3'b111;
    logic [2:0]  force_empty = 3'b000;

    assign ch_data   = {d2, d1, d0};
    assign ch_level  = {lvl2, lvl1, lvl0};
    assign ch_empty  = emp_reg | force_empty;

    always @(posedge clk) begin
        if (ch_rd_en[0] === 1'b1 && q0.size() > 0) d0 <= q0.pop_front();
        if (ch_rd_en[1] === 1'b1 && q1.size() > 0) d1 <= q1.pop_front();
        if (ch_rd_en[2] === 1'b1 && q2.size() > 0) d2 <= q2.pop_front();
        lvl0    <= 7'(q0.size());
        lvl1    <= 7'(q1.size());
        lvl2    <= 7'(q2.size());
        emp_reg <= {q2.size() == 0, q1.size() == 0, q0.size() == 0};
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  chid;
        logic [31:0] data;
        logic        st;
        logic        en;
        logic [5:0]  len;
    } exp_t;

    exp_t exp_q [$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   words_seen   = 0;
    int   cyc          = 0;
    int   first_cyc    = 0;
    int   last_cyc     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int ch, input int idx);
        return 32'hC000_0000 | (32'(ch) << 16) | 32'(idx);
    endfunction

    task automatic load(input int ch, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            case (ch)
                0:       q0.push_back(word(0, first + k));
                1:       q1.push_back(word(1, first + k));
                default: q2.push_back(word(2, first + k));
            endcase
        end
    endtask

    task automatic exp_pkt(input int ch, input int first, input int len);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.chid = 2'(ch);
            e.data = word(ch, first + k);
            e.st   = (k == 0);
            e.en   = (k == len - 1);
            e.len  = 6'(len);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (ch_rd_en != 3'b000) check("rd_onehot", 64'($countones(ch_rd_en)), 64'd1);
        if (fmt_valid === 1'b1) begin
            words_seen++;
            $display("[TB] word ch=%0d len=%0d data=%h start=%0b end=%0b",
                     fmt_chid, fmt_length, fmt_data, fmt_start, fmt_end);
            if (exp_q.size() == 0) begin
                check("extra_word", 64'(fmt_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("data",  64'(fmt_data),   64'(e.data));
                check("chid",  64'(fmt_chid),   64'(e.chid));
                check("start", 64'(fmt_start),  64'(e.st));
                check("end",   64'(fmt_end),    64'(e.en));
                check("len",   64'(fmt_length), 64'(e.len));
                if (fmt_start) first_cyc = cyc;
                if (fmt_end)   last_cyc  = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) step();
    endtask

    task automatic wait_words(input string tag, input int target);
        int n = 0;
        while (words_seen < target && n < 500) begin
            step();
            n++;
        end
        check({tag, "_reached"}, 64'(words_seen >= target), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},   64'(fmt_req),    64'd0);
        check({tag, "_valid"}, 64'(fmt_valid),  64'd0);
        check({tag, "_rd"},    64'(ch_rd_en),   64'd0);
        check({tag, "_chid"},  64'(fmt_chid),   64'd0);
        check({tag, "_len"},   64'(fmt_length), 64'd0);
        check({tag, "_data"},  64'(fmt_data),   64'd0);
        check({tag, "_se"},    64'({fmt_start, fmt_end}), 64'd0);
    endtask

    // ---------------- tests ----------------
    initial begin
        int base;
        int n;
        rst_n       = 1'b0;
        ch_en       = 3'b000;
        ch_prio     = 6'b00_00_00;
        pkt_len_sel = 3'b000;
        fmt_grant   = 1'b1;
        repeat (3) step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // 1: ch1 (prio 1) beats ch0 (prio 2); both drain in 4-word packets
        ch_prio     = 6'b00_01_10;
        pkt_len_sel = 3'b000;
        load(0, 0, 8);
        load(1, 0, 8);
        exp_pkt(1, 0, 4);
        exp_pkt(1, 4, 4);
        exp_pkt(0, 0, 4);
        exp_pkt(0, 4, 4);
        repeat (2) step();
        ch_en = 3'b011;
        drain("t1");
        ch_en = 3'b000;

        // 2: equal priority, lowest id first
        ch_prio = 6'b00_00_00;
        load(1, 0, 4);
        load(2, 0, 4);
        exp_pkt(1, 0, 4);
        exp_pkt(2, 0, 4);
        repeat (2) step();
        ch_en = 3'b111;
        drain("t2");
        ch_en = 3'b000;

        // 3: one word short of a packet never requests
        pkt_len_sel = 3'b001;
        load(0, 0, 7);
        ch_en = 3'b001;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            check("t3_noreq", 64'(fmt_req), 64'd0);
            step();
        end
        exp_pkt(0, 0, 8);
        load(0, 7, 1);
        step();
        check("t3_noreq_lvl8", 64'(fmt_req), 64'd0);
        step();
        check("t3_req", 64'(fmt_req), 64'd1);
        drain("t3");
        check("t3_level0", 64'(lvl0), 64'd0);
        ch_en = 3'b000;

        // 4: grant withheld; request and channel hold, no reads
        fmt_grant = 1'b0;
        load(2, 0, 8);
        exp_pkt(2, 0, 8);
        repeat (2) step();
        ch_en = 3'b100;
        n = 0;
        while (fmt_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("t4_req_seen", 64'(fmt_req), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("t4_req_hold", 64'(fmt_req),  64'd1);
            check("t4_no_rd",    64'(ch_rd_en), 64'd0);
            check("t4_chid",     64'(fmt_chid), 64'd2);
            if (i == 3) ch_en = 3'b000;
            step();
        end
        fmt_grant = 1'b1;
        drain("t4");

        // 5: empty stall for 3 cycles mid-packet
        pkt_len_sel = 3'b010;
        load(0, 0, 16);
        exp_pkt(0, 0, 16);
        repeat (2) step();
        base  = words_seen;
        ch_en = 3'b001;
        wait_words("t5", base + 5);
        force_empty = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_stall_rd", 64'(ch_rd_en), 64'd0);
        end
        force_empty = 3'b000;
        drain("t5");
        check("t5_span", 64'(last_cyc - first_cyc), 64'd18);
        ch_en = 3'b000;

        // 6: reset after word 5 of 16, then re-arbitrate on what is left
        load(1, 0, 16);
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e.chid = 2'd1;
            e.data = word(1, k);
            e.st   = (k == 0);
            e.en   = 1'b0;
            e.len  = 6'd16;
            exp_q.push_back(e);
        end
        repeat (2) step();
        base  = words_seen;
        ch_en = 3'b010;
        wait_words("t6", base + 5);
        // The read in flight at the reset edge pops word 5, which is lost.
        rst_n       = 1'b0;
        pkt_len_sel = 3'b000;
        exp_pkt(1, 6, 4);
        exp_pkt(1, 10, 4);
        step();
        check_idle_outputs("t6_rst");
        rst_n = 1'b1;
        drain("t6");
        check("t6_level", 64'(lvl1), 64'd2);
        check("t6_noreq", 64'(fmt_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
